zone_cmd_sequencer: RTL

Arbitrates rectangle-zone requests from two sources and turns each granted request into the three-beat command sequence (0xA1 position, 0xA2 size, 0xA3 enable) consumed by the video zone-judge datapath. Issues commands only at a frame-sync rising edge, so zone geometry never changes mid-frame. Sits between the host/UART command decoder and key/auto-scan logic on one side and the zone-judge block on the other, in the video clock domain.

---
 rtl/zone_cmd_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/zone_cmd_sequencer.sv
// Zone command sequencer: round-robin arbitration of two rectangle-zone request
// sources. Each granted request becomes a three-beat command burst (0xA1 position,
// 0xA2 size, 0xA3 enable), issued only after a frame-sync rising edge.
// Latency: the request is accepted in IDLE. The beats appear in the three cycles
// after the sampled vs edge, and the block is back in IDLE one cycle after that.
// Backpressure: req*_ready is high only in IDLE. A source that loses arbitration
// must hold its valid until a later IDLE cycle.
// Ports:
//   clk, rstn                        video clock, async active-low reset
//   vs_i                             frame sync level (rising edge = frame start)
//   req{0,1}_valid/ready/x/y/l/h     request handshake and rectangle fields
//   cmd_vaild/cmd_code/para_list     command strobe, held code, parameters
//   busy, grant_id                   sequence in flight, last accepted source
// Build option: define ZONE_CLAMP_EN to clamp latched fields to the active area.
module zone_cmd_sequencer (
   input  logic        clk,
   input  logic        rstn,
   input  logic        vs_i,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [10:0] req0_x,
   input  logic [10:0] req0_y,
   input  logic [10:0] req0_l,
   input  logic [10:0] req0_h,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [10:0] req1_x,
   input  logic [10:0] req1_y,
   input  logic [10:0] req1_l,
   input  logic [10:0] req1_h,
   output logic        cmd_vaild,
   output logic [7:0]  cmd_code,
   output logic [31:0] para_list,
   output logic        busy,
   output logic        grant_id
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_VS   = 3'd1,
      SEND_POS  = 3'd2,
      SEND_SIZE = 3'd3,
      SEND_EN   = 3'd4
   } state_t;

   state_t      state_q;
   logic        vs_d_q;
   logic        last_q;      // last granted source, for round robin
   logic [10:0] x_q, y_q, l_q, h_q;
   logic        cmd_vaild_q;
   logic [7:0]  cmd_code_q;
   logic [31:0] para_list_q;
   logic        busy_q;
   logic        grant_id_q;

   logic        grant_vld;
   logic        grant_sel;
   logic [10:0] sel_x, sel_y, sel_l, sel_h;
   logic [10:0] lat_x_d, lat_y_d, lat_l_d, lat_h_d;
   logic        vs_rise;

   assign vs_rise    = vs_i & ~vs_d_q;
   assign req0_ready = (state_q == IDLE);
   assign req1_ready = (state_q == IDLE);

   assign cmd_vaild  = cmd_vaild_q;
   assign cmd_code   = cmd_code_q;
   assign para_list  = para_list_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;

   // A tie goes to the source that did not win last time.
   always_comb begin
      grant_vld = req0_valid | req1_valid;
      grant_sel = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_sel = ~last_q;
      end else if (req1_valid) begin
         grant_sel = 1'b1;
      end
      sel_x = grant_sel ? req1_x : req0_x;
      sel_y = grant_sel ? req1_y : req0_y;
      sel_l = grant_sel ? req1_l : req0_l;
      sel_h = grant_sel ? req1_h : req0_h;
   end

`ifdef ZONE_CLAMP_EN
   localparam int H_ACTIVE = 1280;
   localparam int V_ACTIVE = 720;

   logic [11:0] l_lim, h_lim;

   // Clamp the origin first; the extent limit derives from the clamped origin.
   // The limits are at most H_ACTIVE / V_ACTIVE, so 12 bits never wrap.
   always_comb begin
      lat_x_d = (sel_x > 11'(H_ACTIVE - 1)) ? 11'(H_ACTIVE - 1) : sel_x;
      lat_y_d = (sel_y > 11'(V_ACTIVE - 1)) ? 11'(V_ACTIVE - 1) : sel_y;
      l_lim   = 12'(H_ACTIVE) - {1'b0, lat_x_d};
      h_lim   = 12'(V_ACTIVE) - {1'b0, lat_y_d};
      lat_l_d = ({1'b0, sel_l} > l_lim) ? l_lim[10:0] : sel_l;
      lat_h_d = ({1'b0, sel_h} > h_lim) ? h_lim[10:0] : sel_h;
   end
`else
   always_comb begin
      lat_x_d = sel_x;
      lat_y_d = sel_y;
      lat_l_d = sel_l;
      lat_h_d = sel_h;
   end
`endif

   // Each state names the beat currently on the outputs. The beat is registered
   // on entry to that state, so the strobes follow the vs edge with no gap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         vs_d_q      <= 1'b0;
         last_q      <= 1'b1;
         x_q         <= '0;
         y_q         <= '0;
         l_q         <= '0;
         h_q         <= '0;
         cmd_vaild_q <= 1'b0;
         cmd_code_q  <= 8'h00;
         para_list_q <= '0;
         busy_q      <= 1'b0;
         grant_id_q  <= 1'b0;
      end else begin
         vs_d_q      <= vs_i;
         cmd_vaild_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  x_q        <= lat_x_d;
                  y_q        <= lat_y_d;
                  l_q        <= lat_l_d;
                  h_q        <= lat_h_d;
                  grant_id_q <= grant_sel;
                  last_q     <= grant_sel;
                  busy_q     <= 1'b1;
                  state_q    <= WAIT_VS;
               end
            end
            WAIT_VS: begin
               if (vs_rise) begin
                  cmd_vaild_q <= 1'b1;
                  cmd_code_q  <= 8'hA1;
                  para_list_q <= {10'd0, x_q, y_q};
                  state_q     <= SEND_POS;
               end
            end
            SEND_POS: begin
               cmd_vaild_q <= 1'b1;
               cmd_code_q  <= 8'hA2;
               para_list_q <= {10'd0, l_q, h_q};
               state_q     <= SEND_SIZE;
            end
            SEND_SIZE: begin
               cmd_vaild_q <= 1'b1;
               cmd_code_q  <= 8'hA3;
               para_list_q <= '0;
               state_q     <= SEND_EN;
            end
            SEND_EN: begin
               // cmd_code stays at 0xA3: the zone judge uses it as a level enable.
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
